// File: rtl/fft_frame_serializer_pkg.sv
// Shared types for the FFT frame serializer: complex bin, frame, read-side state.
package fft_frame_serializer_pkg;

   localparam int FFT_N  = 8;
   localparam int CPLX_W = 16;

   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } complex_product_t;

   typedef complex_product_t [FFT_N-1:0] fft_frame_t;

   typedef enum logic {
      RD_IDLE,
      RD_STREAM
   } rd_state_e;

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry frame register bank with its full flag and bin read mux.
module fft_frame_bank
   import fft_frame_serializer_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int IDX_W = $clog2(N)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic                     set,
   input  logic                     clr,
   input  complex_product_t [N-1:0] wr_frame,
   input  logic [IDX_W-1:0]         rd_addr,
   output complex_product_t         rd_data,
   output logic                     full
);

   complex_product_t [N-1:0] data_q, data_d;
   logic                     full_q, full_d;

   // set after clr: a refill in the same cycle as the final read keeps the bank full
   always_comb begin
      data_d = we ? wr_frame : data_q;
      full_d = full_q;
      if (clr) full_d = 1'b0;
      if (set) full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   always_ff @(posedge clk) begin
      if (reset) full_q <= 1'b0;
      else       full_q <= full_d;
   end

   assign rd_data = data_q[rd_addr];
   assign full    = full_q;

endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong capture of parallel FFT frames, streamed out one bin per cycle.
// Define FFT_SERIALIZER_FFTSHIFT_EN to stream bins in fftshift order (DC in the middle).
module fft_frame_serializer
   import fft_frame_serializer_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int IDX_W = $clog2(N)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  complex_product_t [N-1:0] in_frame,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output complex_product_t         out_data,
   output logic [IDX_W-1:0]         out_index,
   output logic                     out_last,
   output logic                     overflow
);

   logic                   wr_sel_q, wr_sel_d;
   logic                   rd_sel_q, rd_sel_d;
   logic [IDX_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic                   overflow_q, overflow_d;
   logic [IDX_W-1:0]       rd_addr;
   logic [1:0]             bank_full, bank_set, bank_clr;
   complex_product_t [1:0] bank_rd_data;
   rd_state_e              rd_state;
   logic                   xfer, frame_done, wr_en;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_frame_bank #(
         .N     (N),
         .IDX_W (IDX_W)
      ) u_bank (
         .clk      (clk),
         .reset    (reset),
         .we       (bank_set[b]),
         .set      (bank_set[b]),
         .clr      (bank_clr[b]),
         .wr_frame (in_frame),
         .rd_addr  (rd_addr),
         .rd_data  (bank_rd_data[b]),
         .full     (bank_full[b])
      );
   end

   // Read-side state is the full flag of the selected bank; no extra state flop.
   always_comb begin
      rd_state   = bank_full[rd_sel_q] ? RD_STREAM : RD_IDLE;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      xfer       = 1'b0;
      frame_done = 1'b0;
`ifdef FFT_SERIALIZER_FFTSHIFT_EN
      rd_addr    = rd_ptr_q + IDX_W'(N / 2);
`else
      rd_addr    = rd_ptr_q;
`endif
      out_data   = bank_rd_data[rd_sel_q];
      out_index  = '0;
      case (rd_state)
         RD_IDLE: ;
         RD_STREAM: begin
            out_valid  = 1'b1;
            out_index  = rd_addr;
            out_last   = (rd_ptr_q == IDX_W'(N - 1));
            xfer       = out_ready;
            frame_done = out_ready && out_last;
         end
         default: ;
      endcase
   end

   // out_ready only reaches in_ready through the free-and-fill term.
   always_comb begin
      in_ready   = !bank_full[wr_sel_q] || (frame_done && (rd_sel_q == wr_sel_q));
      wr_en      = in_valid && in_ready;
      bank_set   = '0;
      bank_clr   = '0;
      if (wr_en)      bank_set[wr_sel_q] = 1'b1;
      if (frame_done) bank_clr[rd_sel_q] = 1'b1;
      wr_sel_d   = wr_sel_q ^ wr_en;
      rd_sel_d   = rd_sel_q ^ frame_done;
      rd_ptr_d   = xfer ? rd_ptr_q + 1'b1 : rd_ptr_q;
      overflow_d = in_valid && !in_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomised bench for fft_frame_serializer against a frame-queue reference model.
module tb_fft_frame_serializer;
   import fft_frame_serializer_pkg::*;

   localparam int N     = FFT_N;
   localparam int IDX_W = $clog2(N);

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     in_valid = 1'b0;
   complex_product_t [N-1:0] in_frame = '0;
   logic                     in_ready;
   logic                     out_valid;
   logic                     out_ready = 1'b0;
   complex_product_t         out_data;
   logic [IDX_W-1:0]         out_index;
   logic                     out_last;
   logic                     overflow;

   int total = 0;
   int bad   = 0;

   fft_frame_serializer #(.N(N), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_frame  (in_frame),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   function automatic int bin_of(input int pos);
`ifdef FFT_SERIALIZER_FFTSHIFT_EN
      return (pos + N / 2) % N;
`else
      return pos;
`endif
   endfunction

   function automatic fft_frame_t rand_frame();
      fft_frame_t f;
      for (int k = 0; k < N; k++) begin
         f[k].re = CPLX_W'($urandom);
         f[k].im = CPLX_W'($urandom);
      end
      return f;
   endfunction

   // Reference model: frames held (max two), position within the head frame.
   fft_frame_t       mq[$];
   int               pos = 0;
   int               n_acc = 0;
   logic             ovf_exp = 1'b0;
   logic             prev_stall = 1'b0;
   complex_product_t prev_data;
   logic [IDX_W-1:0] prev_index;
   logic             prev_last;

   always @(negedge clk) begin
      logic exp_rdy, xfer_m, last_m;
      if (reset) begin
         mq.delete();
         pos        = 0;
         ovf_exp    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         xfer_m  = (mq.size() > 0) && out_ready;
         last_m  = (pos == N - 1);
         exp_rdy = (mq.size() < 2) || (xfer_m && last_m);
         total++;
         if (out_valid !== (mq.size() > 0)) begin
            bad++; $display("FAIL mon_valid t=%0t got=%b want=%b", $time, out_valid, mq.size() > 0);
         end
         total++;
         if (in_ready !== exp_rdy) begin
            bad++; $display("FAIL mon_in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
         end
         total++;
         if (overflow !== ovf_exp) begin
            bad++; $display("FAIL mon_overflow t=%0t got=%b want=%b", $time, overflow, ovf_exp);
         end
         if (mq.size() > 0) begin
            total++;
            if (out_data !== mq[0][bin_of(pos)] || out_index !== IDX_W'(bin_of(pos)) ||
                out_last !== last_m) begin
               bad++;
               $display("FAIL mon_bin t=%0t got d=%h i=%0d l=%b want d=%h i=%0d l=%b", $time,
                        out_data, out_index, out_last, mq[0][bin_of(pos)], bin_of(pos), last_m);
            end
         end
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev_data || out_index !== prev_index ||
                out_last !== prev_last) begin
               bad++;
               $display("FAIL mon_stable t=%0t got v=%b d=%h i=%0d want v=1 d=%h i=%0d", $time,
                        out_valid, out_data, out_index, prev_data, prev_index);
            end
         end
         prev_stall = (mq.size() > 0) && !out_ready;
         prev_data  = out_data;
         prev_index = out_index;
         prev_last  = out_last;
         if (xfer_m) begin
            pos++;
            if (pos == N) begin
               void'(mq.pop_front());
               pos = 0;
            end
         end
         ovf_exp = in_valid && !exp_rdy;
         if (in_valid && exp_rdy) begin
            mq.push_back(in_frame);
            n_acc++;
         end
      end
   end

   task automatic send_frame(input fft_frame_t fr);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_frame = fr;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      out_ready = 1'b1;
      while (mq.size() > 0 && cyc < 1000) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      total++;
      if (mq.size() != 0) begin
         bad++; $display("FAIL drain_timeout frames_left=%0d want=0", mq.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 ||
          out_index !== '0 || out_last !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got v=%b r=%b o=%b i=%0d l=%b want v=0 r=1 o=0 i=0 l=0",
                  out_valid, in_ready, overflow, out_index, out_last);
      end
   endtask

   task automatic test_single();
      fft_frame_t       f;
      complex_product_t e;
      for (int k = 0; k < N; k++) begin
         f[k].re = CPLX_W'(k);
         f[k].im = CPLX_W'(-k);
      end
      out_ready = 1'b1;
      send_frame(f);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         e.re = CPLX_W'(bin_of(i));
         e.im = CPLX_W'(-bin_of(i));
         total++;
         if (out_valid !== 1'b1 || out_index !== IDX_W'(bin_of(i)) || out_data !== e ||
             out_last !== (i == N - 1) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_bin%0d got v=%b i=%0d d=%h l=%b r=%b want v=1 i=%0d d=%h l=%b r=1",
                     i, out_valid, out_index, out_data, out_last, in_ready, bin_of(i), e, i == N - 1);
         end
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL single_after got v=%b want v=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      fft_frame_t b;
      out_ready = 1'b1;
      send_frame(rand_frame());
      b = rand_frame();
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL b2b_cycle%0d got v=%b o=%b want v=1 o=0", i, out_valid, overflow);
         end
         @(posedge clk); #1;
         in_valid = (i == N - 2);
         in_frame = b;
      end
      drain();
   endtask

   task automatic test_overflow();
      int pulses = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         in_valid = (i < 3);
         in_frame = rand_frame();
         @(negedge clk);
         if (overflow === 1'b1) pulses++;
         if (i == 2) begin
            total++;
            if (in_ready !== 1'b0) begin
               bad++; $display("FAIL ovf_in_ready got=%b want=0", in_ready);
            end
         end
      end
      total++;
      if (pulses != 1) begin
         bad++; $display("FAIL ovf_pulses got=%0d want=1", pulses);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_free_and_fill();
      out_ready = 1'b0;
      send_frame(rand_frame());
      send_frame(rand_frame());
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (N - 1) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_frame = rand_frame();
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_last !== 1'b1) begin
         bad++; $display("FAIL fill_same_cycle got r=%b l=%b want r=1 l=1", in_ready, out_last);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (overflow !== 1'b0) begin
         bad++; $display("FAIL fill_overflow got=%b want=0", overflow);
      end
      drain();
   endtask

   task automatic test_random();
      int start = n_acc;
      int cyc   = 0;
      while (n_acc - start < 20 && cyc < 3000) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) == 0);
         in_frame  = rand_frame();
         cyc++;
      end
      total++;
      if (n_acc - start < 20) begin
         bad++; $display("FAIL random_accept got=%0d want=20", n_acc - start);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send_frame(rand_frame());
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL rstmid_state got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      send_frame(rand_frame());
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_index !== IDX_W'(bin_of(0))) begin
         bad++; $display("FAIL rstmid_first got v=%b i=%0d want v=1 i=%0d", out_valid, out_index, bin_of(0));
      end
      drain();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_free_and_fill();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Sits directly downstream of the N-point radix-2 FFT engine.
- Captures each parallel N-bin result frame on the engine's valid strobe into a ping-pong double buffer.
- Streams bins out one per cycle in natural index order over a valid/ready handshake, with bin index and end-of-frame marker.
- Decouples the FFT's burst output from slower consumers (equaliser, demapper) and reports frames lost to backpressure.

Parameters:
- N, 8, FFT size in bins; power of two, 8..4096.
- IDX_W, $clog2(N), width of the bin index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle strobe: in_frame holds a complete result frame
- in_frame  in  complex_product_t [N]  parallel FFT bins, element k = bin k
- in_ready  out  1  high when the write bank can accept a frame this cycle
- out_valid  out  1  out_data/out_index/out_last are valid
- out_ready  in  1  consumer accepts the current bin
- out_data  out  complex_product_t  current bin value
- out_index  out  IDX_W  bin number of out_data
- out_last  out  1  high with the final bin of a frame (read pointer = N-1)
- overflow  out  1  one-cycle pulse: an incoming frame was dropped

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Storage: two banks of N complex_product_t registers; per-bank full flag; wr_sel, rd_sel bank pointers; rd_ptr of IDX_W bits.
- Reset values: banks are not cleared; full flags 0; wr_sel = 0; rd_sel = 0; rd_ptr = 0; out_valid = 0; out_last = 0; overflow = 0; in_ready = 1; out_index = 0.
- in_ready is registered-state-only: !full[wr_sel] OR (bank wr_sel is being freed this cycle).
- Write: in_valid && in_ready copies in_frame into bank wr_sel, sets full[wr_sel], toggles wr_sel.
- Drop: in_valid && !in_ready leaves all state unchanged, discards the frame, and pulses overflow the next cycle.
- Read side, per bank, state machine:
  - IDLE: full[rd_sel] = 0, out_valid = 0.
  - STREAM: full[rd_sel] = 1, out_valid = 1, out_data = bank[rd_sel][rd_ptr], out_index = rd_ptr.
  - A transfer is out_valid && out_ready; it increments rd_ptr.
  - Transfer at rd_ptr = N-1 with out_last = 1: clears full[rd_sel], toggles rd_sel, wraps rd_ptr to 0.
  - If the other bank is full, streaming continues with no bubble.
- Latency: frame accepted in cycle t; bin 0 presented with out_valid in cycle t+1 when the read side was IDLE.
- Throughput: one bin per cycle with out_ready held high; sustains one frame every N cycles.
- Handshake rules:
  - Once out_valid rises, out_data/out_index/out_last are held stable until the transfer completes.
  - out_valid never drops without a transfer (except on reset).
- Simultaneous free-and-fill: a final-bin transfer from bank B and in_valid targeting bank B in the same cycle are both accepted. The write wins; full[B] stays 1.
- Both banks full: in_ready = 0 until the last bin of rd_sel is transferred.
- No combinational path from in_valid/in_frame to any output. out_ready reaches in_ready only through the free-and-fill term.
- Reset mid-frame: all partial frames are discarded; no out_valid in the cycle after reset deasserts.
- out_data values pass through unmodified; no scaling or saturation.

Optional Feature:
- Macro: FFT_SERIALIZER_FFTSHIFT_EN.
- Defined: read address is (rd_ptr + N/2) mod N, so bins stream from -N/2..N/2-1 with DC at position N/2. out_index reports the true bin number (rd_ptr + N/2) mod N. out_last still marks the N-th transfer.
- Undefined: natural order 0..N-1; out_index = rd_ptr.

Decomposition:
- Shared package: complex_product_t (already there); a frame type (complex_product_t array of N) if parameterisable there; and the FFT size constant used by the top level.
- Natural sub-module: fft_frame_bank. It holds one N-entry register bank with write-enable, full flag, set/clear ports and read mux. It is instantiated twice; the ping-pong control stays in the parent.

Test Plan:
- N=8, single frame bins k -> (re=k, im=-k), out_ready=1: out_valid from t+1 for 8 cycles; index 0..7; data (k,-k); out_last only at index 7; in_ready stays 1.
- Back-to-back frames A then B, 8 cycles apart, out_ready=1: 16 consecutive transfers with no bubble; A0..A7 then B0..B7; no overflow.
- out_ready=0, three frames sent: first two accepted; third raises overflow for exactly 1 cycle; in_ready=0. Releasing out_ready then yields frames 1 and 2 intact.
- Both banks full, frame C presented in the same cycle as the last-bin transfer of frame 1: C accepted; streamed after frame 2; no overflow.
- Random out_ready (50%) over 20 frames: scoreboard matches every bin; data/index held stable while stalled.
- Reset asserted at bin 3 of a frame: next cycle out_valid=0, in_ready=1; a new frame then streams from index 0.
- With FFT_SERIALIZER_FFTSHIFT_EN, N=8: out_index sequence 4,5,6,7,0,1,2,3, with matching data.
